// File: rtl/rs_station_if.sv
// Bundle of the dispatch, CDB, squash, issue and status signals of the
// reservation station. The slave side is the station itself; the master side
// is whatever feeds dispatch/CDB/squash and consumes issue.
interface rs_station_if #(
    parameter int RS_SZ     = 8,
    parameter int TAG_W     = 5,
    parameter int PAYLOAD_W = 64
);
    localparam int CNT_W = $clog2(RS_SZ) + 1;

    // dispatch from the map table
    logic                 dispatch_valid;
    logic [TAG_W-1:0]     dp_rob_tag;
    logic [TAG_W-1:0]     dp_tag_a;
    logic [TAG_W-1:0]     dp_tag_b;
    logic                 dp_tplus_a;
    logic                 dp_tplus_b;
    logic [PAYLOAD_W-1:0] dp_payload;

    // common data bus broadcast
    logic                 cdb_valid;
    logic [TAG_W-1:0]     cdb_tag;

    // branch squash
    logic                 mispredict;
    logic [TAG_W-1:0]     br_rob_tag;
    logic [TAG_W-1:0]     rob_tail;

    // issue handshake towards execute
    logic                 issue_valid;
    logic                 issue_ready;
    logic [TAG_W-1:0]     issue_rob_tag;
    logic [TAG_W-1:0]     issue_tag_a;
    logic [TAG_W-1:0]     issue_tag_b;
    logic [PAYLOAD_W-1:0] issue_payload;

    // occupancy status
    logic                 rs_full;
    logic [CNT_W-1:0]     free_count;

    modport master (
        output dispatch_valid, dp_rob_tag, dp_tag_a, dp_tag_b,
               dp_tplus_a, dp_tplus_b, dp_payload,
               cdb_valid, cdb_tag, mispredict, br_rob_tag, rob_tail,
               issue_ready,
        input  issue_valid, issue_rob_tag, issue_tag_a, issue_tag_b,
               issue_payload, rs_full, free_count
    );

    modport slave (
        input  dispatch_valid, dp_rob_tag, dp_tag_a, dp_tag_b,
               dp_tplus_a, dp_tplus_b, dp_payload,
               cdb_valid, cdb_tag, mispredict, br_rob_tag, rob_tail,
               issue_ready,
        output issue_valid, issue_rob_tag, issue_tag_a, issue_tag_b,
               issue_payload, rs_full, free_count
    );
endinterface

// File: rtl/rs_station.sv
// Reservation station: one dispatch per cycle into the lowest free slot,
// CDB wakeup of source operands, lowest-index-ready issue over valid/ready,
// and selective squash of entries younger than a mispredicted branch.
module rs_station #(
    parameter int RS_SZ     = 8,
    parameter int TAG_W     = 5,
    parameter int PAYLOAD_W = 64
) (
    input  logic        clock,
    input  logic        reset,
    rs_station_if.slave bus
);
    localparam int IDX_W = $clog2(RS_SZ);
    localparam int CNT_W = IDX_W + 1;

    // rob tag t is younger than the branch and not younger than the tail
    function automatic logic in_squash_window(input logic [TAG_W-1:0] t,
                                              input logic [TAG_W-1:0] br,
                                              input logic [TAG_W-1:0] tail);
        logic hit;
        if (br <= tail) hit = (t > br) && (t <= tail);
        else            hit = (t > br) || (t <= tail);
        return hit;
    endfunction

    // index of the lowest set bit of vec (0 when vec is empty)
    function automatic logic [IDX_W-1:0] lowest_set(input logic [RS_SZ-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
            else        idx = idx;
        end
        return idx;
    endfunction

    // number of clear bits in vec
    function automatic logic [CNT_W-1:0] count_zeros(input logic [RS_SZ-1:0] vec);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            if (!vec[i]) cnt = cnt + CNT_W'(1);
            else         cnt = cnt;
        end
        return cnt;
    endfunction

    logic [RS_SZ-1:0]     busy_r;
    logic [RS_SZ-1:0]     rdy_a_r;
    logic [RS_SZ-1:0]     rdy_b_r;
    logic [TAG_W-1:0]     rob_tag_r [RS_SZ];
    logic [TAG_W-1:0]     tag_a_r   [RS_SZ];
    logic [TAG_W-1:0]     tag_b_r   [RS_SZ];
    logic [PAYLOAD_W-1:0] payload_r [RS_SZ];

    logic [RS_SZ-1:0]     ready_vec_s;
    logic [IDX_W-1:0]     alloc_idx_s;
    logic [IDX_W-1:0]     cand_idx_s;
    logic                 cand_found_s;
    logic [CNT_W-1:0]     free_cnt_s;
    logic                 full_s;
    logic                 alloc_en_s;
    logic                 issue_valid_s;
    logic                 issue_fire_s;
    logic                 cdb_hit_s;
    logic                 cap_rdy_a_s;
    logic                 cap_rdy_b_s;

    // slot selection, occupancy and handshake qualification
    always_comb begin
        ready_vec_s   = busy_r & rdy_a_r & rdy_b_r;
        cand_found_s  = |ready_vec_s;
        cand_idx_s    = lowest_set(ready_vec_s);
        alloc_idx_s   = lowest_set(~busy_r);
        free_cnt_s    = count_zeros(busy_r);
        full_s        = (free_cnt_s == CNT_W'(0));
        alloc_en_s    = bus.dispatch_valid && !full_s && !bus.mispredict;
        issue_valid_s = cand_found_s && !bus.mispredict;
        issue_fire_s  = issue_valid_s && bus.issue_ready;
        cdb_hit_s     = bus.cdb_valid && (bus.cdb_tag != TAG_W'(0));
        // operands captured at dispatch may already be ready, including a
        // broadcast of the producer in the very same cycle
        cap_rdy_a_s   = (bus.dp_tag_a == TAG_W'(0)) || bus.dp_tplus_a ||
                        (cdb_hit_s && (bus.cdb_tag == bus.dp_tag_a));
        cap_rdy_b_s   = (bus.dp_tag_b == TAG_W'(0)) || bus.dp_tplus_b ||
                        (cdb_hit_s && (bus.cdb_tag == bus.dp_tag_b));
    end

    // presented issue fields, forced to zero when nothing is offered
    always_comb begin
        bus.issue_valid = issue_valid_s;
        if (issue_valid_s) begin
            bus.issue_rob_tag = rob_tag_r[cand_idx_s];
            bus.issue_tag_a   = tag_a_r[cand_idx_s];
            bus.issue_tag_b   = tag_b_r[cand_idx_s];
            bus.issue_payload = payload_r[cand_idx_s];
        end else begin
            bus.issue_rob_tag = TAG_W'(0);
            bus.issue_tag_a   = TAG_W'(0);
            bus.issue_tag_b   = TAG_W'(0);
            bus.issue_payload = PAYLOAD_W'(0);
        end
    end

    assign bus.free_count = free_cnt_s;
    assign bus.rs_full    = full_s;

    // entry state: squash beats issue beats allocation; wakeup for survivors
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_r  <= '0;
            rdy_a_r <= '0;
            rdy_b_r <= '0;
            for (int i = 0; i < RS_SZ; i++) begin
                rob_tag_r[i] <= TAG_W'(0);
                tag_a_r[i]   <= TAG_W'(0);
                tag_b_r[i]   <= TAG_W'(0);
                payload_r[i] <= PAYLOAD_W'(0);
            end
        end else begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (busy_r[i] && cdb_hit_s && (tag_a_r[i] == bus.cdb_tag)) rdy_a_r[i] <= 1'b1;
                if (busy_r[i] && cdb_hit_s && (tag_b_r[i] == bus.cdb_tag)) rdy_b_r[i] <= 1'b1;

                if (bus.mispredict) begin
                    if (busy_r[i] && in_squash_window(rob_tag_r[i], bus.br_rob_tag, bus.rob_tail))
                        busy_r[i] <= 1'b0;
                end else if (issue_fire_s && (cand_idx_s == IDX_W'(i))) begin
                    busy_r[i] <= 1'b0;
                end else if (alloc_en_s && (alloc_idx_s == IDX_W'(i))) begin
                    busy_r[i]    <= 1'b1;
                    rob_tag_r[i] <= bus.dp_rob_tag;
                    tag_a_r[i]   <= bus.dp_tag_a;
                    tag_b_r[i]   <= bus.dp_tag_b;
                    rdy_a_r[i]   <= cap_rdy_a_s;
                    rdy_b_r[i]   <= cap_rdy_b_s;
                    payload_r[i] <= bus.dp_payload;
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: directed scenarios plus a randomized
// run, all compared against a slot-array reference model kept in the bench.
module tb_rs_station;
    localparam int RS_SZ     = 8;
    localparam int TAG_W     = 5;
    localparam int PAYLOAD_W = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;

    rs_station_if #(.RS_SZ(RS_SZ), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)) bus ();

    rs_station #(.RS_SZ(RS_SZ), .TAG_W(TAG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: one record per slot
    bit                   m_busy [RS_SZ];
    bit                   m_ra   [RS_SZ];
    bit                   m_rb   [RS_SZ];
    logic [TAG_W-1:0]     m_rob  [RS_SZ];
    logic [TAG_W-1:0]     m_ta   [RS_SZ];
    logic [TAG_W-1:0]     m_tb   [RS_SZ];
    logic [PAYLOAD_W-1:0] m_pay  [RS_SZ];

    bit                   e_valid;
    int                   e_slot;
    logic [TAG_W-1:0]     e_rob, e_ta, e_tb;
    logic [PAYLOAD_W-1:0] e_pay;
    logic [3:0]           e_free;
    bit                   e_full;

    task automatic model_clear();
        for (int i = 0; i < RS_SZ; i++) begin
            m_busy[i] = 1'b0; m_ra[i] = 1'b0; m_rb[i] = 1'b0;
        end
    endtask

    // expected outputs from current model state and current inputs
    task automatic model_eval();
        int nfree;
        nfree  = 0;
        e_slot = -1;
        for (int i = 0; i < RS_SZ; i++) begin
            if (!m_busy[i]) nfree++;
            if (m_busy[i] && m_ra[i] && m_rb[i] && e_slot < 0) e_slot = i;
        end
        e_free  = 4'(nfree);
        e_full  = (nfree == 0);
        e_valid = (e_slot >= 0) && !bus.mispredict;
        e_rob = '0; e_ta = '0; e_tb = '0; e_pay = '0;
        if (e_valid) begin
            e_rob = m_rob[e_slot]; e_ta = m_ta[e_slot];
            e_tb = m_tb[e_slot]; e_pay = m_pay[e_slot];
        end
    endtask

    // younger than the branch, no younger than the tail, in modular tag order
    function automatic bit squashed(input logic [TAG_W-1:0] t);
        logic [TAG_W-1:0] d, w;
        d = t - bus.br_rob_tag;
        w = bus.rob_tail - bus.br_rob_tag;
        return (d != '0) && (d <= w);
    endfunction

    function automatic bit src_ready(input logic [TAG_W-1:0] t, input bit tplus);
        return (t == '0) || tplus || (bus.cdb_valid && bus.cdb_tag != '0 && bus.cdb_tag == t);
    endfunction

    // state update for one rising edge, using the inputs present at the edge
    task automatic model_clock();
        int a;
        a = -1;
        for (int i = 0; i < RS_SZ; i++) if (!m_busy[i] && a < 0) a = i;
        for (int i = 0; i < RS_SZ; i++) begin
            if (m_busy[i] && bus.cdb_valid && bus.cdb_tag != '0) begin
                if (m_ta[i] == bus.cdb_tag) m_ra[i] = 1'b1;
                if (m_tb[i] == bus.cdb_tag) m_rb[i] = 1'b1;
            end
        end
        if (bus.mispredict) begin
            for (int i = 0; i < RS_SZ; i++) if (m_busy[i] && squashed(m_rob[i])) m_busy[i] = 1'b0;
        end else begin
            if (e_valid && bus.issue_ready) m_busy[e_slot] = 1'b0;
            if (bus.dispatch_valid && a >= 0) begin
                m_busy[a] = 1'b1;
                m_rob[a]  = bus.dp_rob_tag;
                m_ta[a]   = bus.dp_tag_a;
                m_tb[a]   = bus.dp_tag_b;
                m_ra[a]   = src_ready(bus.dp_tag_a, bus.dp_tplus_a);
                m_rb[a]   = src_ready(bus.dp_tag_b, bus.dp_tplus_b);
                m_pay[a]  = bus.dp_payload;
            end
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clock);
        model_clock();
        #1;
    endtask

    task automatic peek();
        #2;
        model_eval();
    endtask

    task automatic idle();
        bus.dispatch_valid = 1'b0;
        bus.dp_rob_tag = '0; bus.dp_tag_a = '0; bus.dp_tag_b = '0;
        bus.dp_tplus_a = 1'b0; bus.dp_tplus_b = 1'b0; bus.dp_payload = '0;
        bus.cdb_valid = 1'b0; bus.cdb_tag = '0;
        bus.mispredict = 1'b0; bus.br_rob_tag = '0; bus.rob_tail = '0;
    endtask

    task automatic dispatch(input int rob, input int ta, input int tb);
        bus.dispatch_valid = 1'b1;
        bus.dp_rob_tag = TAG_W'(rob);
        bus.dp_tag_a = TAG_W'(ta); bus.dp_tag_b = TAG_W'(tb);
        bus.dp_tplus_a = 1'b0; bus.dp_tplus_b = 1'b0;
        bus.dp_payload = {$urandom, $urandom};
    endtask

    task automatic flush();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_clear();
        idle();
        bus.issue_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        bus.issue_ready = 1'b0;
        #2;
        n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.issue_valid); end
        n_checks++; if (bus.free_count !== 4'd8) begin n_fail++; $display("FAIL reset_free got %0d want 8", bus.free_count); end
        n_checks++; if (bus.rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", bus.rs_full); end
        n_checks++; if (bus.issue_payload !== 64'd0) begin n_fail++; $display("FAIL reset_payload got %h want 0", bus.issue_payload); end
        @(posedge clock); #1;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic test_single();
        dispatch(3, 0, 0);
        tick(); idle(); peek();
        n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b want 1", bus.issue_valid); end
        n_checks++; if (bus.issue_rob_tag !== 5'd3) begin n_fail++; $display("FAIL single_rob got %0d want 3", bus.issue_rob_tag); end
        n_checks++; if (bus.issue_payload !== e_pay) begin n_fail++; $display("FAIL single_payload got %h want %h", bus.issue_payload, e_pay); end
        n_checks++; if (bus.free_count !== 4'd7) begin n_fail++; $display("FAIL single_free got %0d want 7", bus.free_count); end
        bus.issue_ready = 1'b1;
        tick(); peek();
        n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL single_after_valid got %0b want 0", bus.issue_valid); end
        n_checks++; if (bus.free_count !== 4'd8) begin n_fail++; $display("FAIL single_after_free got %0d want 8", bus.free_count); end
        bus.issue_ready = 1'b0;
    endtask

    task automatic test_wakeup();
        dispatch(5, 2, 0);
        tick(); idle(); peek();
        n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_wait got %0b want 0", bus.issue_valid); end
        tick();
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd2;
        peek();
        n_checks++; if (bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL wake_same_cycle got %0b want 0", bus.issue_valid); end
        tick(); idle(); peek();
        n_checks++; if (bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL wake_valid got %0b want 1", bus.issue_valid); end
        n_checks++; if (bus.issue_tag_a !== 5'd2) begin n_fail++; $display("FAIL wake_tag_a got %0d want 2", bus.issue_tag_a); end
        n_checks++; if (bus.issue_rob_tag !== 5'd5) begin n_fail++; $display("FAIL wake_rob got %0d want 5", bus.issue_rob_tag); end
        bus.issue_ready = 1'b1;
        tick(); bus.issue_ready = 1'b0;
        // producer broadcast in the dispatch cycle itself
        dispatch(6, 0, 7);
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd7;
        tick(); idle(); peek();
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_tag !== 5'd6) begin n_fail++; $display("FAIL wake_bypass got %0b/%0d want 1/6", bus.issue_valid, bus.issue_rob_tag); end
        n_checks++; if (bus.issue_tag_b !== 5'd7) begin n_fail++; $display("FAIL wake_bypass_tag_b got %0d want 7", bus.issue_tag_b); end
        bus.issue_ready = 1'b1;
        tick(); bus.issue_ready = 1'b0;
    endtask

    task automatic test_fill();
        flush();
        for (int k = 0; k < RS_SZ; k++) begin
            dispatch(k + 1, 10 + k, 0);
            tick();
        end
        idle(); peek();
        n_checks++; if (bus.rs_full !== 1'b1 || bus.free_count !== 4'd0) begin n_fail++; $display("FAIL fill_full got %0b/%0d want 1/0", bus.rs_full, bus.free_count); end
        dispatch(9, 0, 0);
        tick(); idle(); peek();
        n_checks++; if (bus.free_count !== 4'd0 || bus.issue_valid !== 1'b0) begin n_fail++; $display("FAIL fill_drop got %0d/%0b want 0/0", bus.free_count, bus.issue_valid); end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd10;
        tick(); idle();
        bus.issue_ready = 1'b1;
        dispatch(20, 0, 0);
        peek();
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_tag !== 5'd1) begin n_fail++; $display("FAIL fill_release got %0b/%0d want 1/1", bus.issue_valid, bus.issue_rob_tag); end
        n_checks++; if (bus.rs_full !== 1'b1) begin n_fail++; $display("FAIL fill_full_during_issue got %0b want 1", bus.rs_full); end
        tick(); idle(); bus.issue_ready = 1'b0; peek();
        n_checks++; if (bus.rs_full !== 1'b0 || bus.free_count !== 4'd1) begin n_fail++; $display("FAIL fill_after got %0b/%0d want 0/1", bus.rs_full, bus.free_count); end
        n_checks++; if (bus.free_count !== e_free) begin n_fail++; $display("FAIL fill_model_free got %0d want %0d", bus.free_count, e_free); end
    endtask

    task automatic test_priority();
        flush();
        dispatch(10, 0, 0); tick();
        dispatch(11, 25, 0); tick();
        dispatch(12, 0, 0); tick();
        idle();
        for (int k = 0; k < 3; k++) begin
            peek();
            n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_tag !== 5'd10) begin n_fail++; $display("FAIL prio_hold got %0b/%0d want 1/10", bus.issue_valid, bus.issue_rob_tag); end
            tick();
        end
        bus.issue_ready = 1'b1;
        tick(); bus.issue_ready = 1'b0; peek();
        n_checks++; if (bus.issue_rob_tag !== 5'd12) begin n_fail++; $display("FAIL prio_next got %0d want 12", bus.issue_rob_tag); end
    endtask

    task automatic test_squash();
        flush();
        dispatch(29, 0, 0); tick();
        dispatch(30, 3, 0); tick();
        dispatch(31, 3, 0); tick();
        dispatch(1, 3, 0);  tick();
        dispatch(2, 3, 0);  tick();
        idle();
        dispatch(9, 0, 0);
        bus.mispredict = 1'b1; bus.br_rob_tag = 5'd30; bus.rob_tail = 5'd2;
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd3;
        bus.issue_ready = 1'b1;
        peek();
        n_checks++; if (bus.issue_valid !== 1'b0 || bus.issue_rob_tag !== 5'd0) begin n_fail++; $display("FAIL squash_valid got %0b/%0d want 0/0", bus.issue_valid, bus.issue_rob_tag); end
        tick(); idle(); bus.issue_ready = 1'b0; peek();
        n_checks++; if (bus.free_count !== 4'd6) begin n_fail++; $display("FAIL squash_wrap_free got %0d want 6", bus.free_count); end
        n_checks++; if (bus.issue_rob_tag !== 5'd29) begin n_fail++; $display("FAIL squash_keep got %0d want 29", bus.issue_rob_tag); end
        bus.issue_ready = 1'b1;
        tick(); bus.issue_ready = 1'b0; peek();
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_tag !== 5'd30) begin n_fail++; $display("FAIL squash_survivor_wake got %0b/%0d want 1/30", bus.issue_valid, bus.issue_rob_tag); end
        // non-wrapping window
        flush();
        for (int k = 3; k <= 7; k++) begin
            dispatch(k, 1, 0); tick();
        end
        idle();
        bus.mispredict = 1'b1; bus.br_rob_tag = 5'd4; bus.rob_tail = 5'd7;
        tick(); idle(); peek();
        n_checks++; if (bus.free_count !== 4'd6) begin n_fail++; $display("FAIL squash_nowrap_free got %0d want 6", bus.free_count); end
        bus.cdb_valid = 1'b1; bus.cdb_tag = 5'd1;
        tick(); idle(); peek();
        n_checks++; if (bus.issue_rob_tag !== 5'd3) begin n_fail++; $display("FAIL squash_nowrap_first got %0d want 3", bus.issue_rob_tag); end
    endtask

    task automatic test_async_reset();
        flush();
        for (int k = 0; k < 5; k++) begin
            dispatch(k + 1, (k == 0) ? 0 : 12, 0); tick();
        end
        idle(); peek();
        n_checks++; if (bus.free_count !== 4'd3 || bus.issue_valid !== 1'b1) begin n_fail++; $display("FAIL async_pre got %0d/%0b want 3/1", bus.free_count, bus.issue_valid); end
        reset = 1'b0;
        #1;
        n_checks++; if (bus.issue_valid !== 1'b0 || bus.issue_rob_tag !== 5'd0) begin n_fail++; $display("FAIL async_valid got %0b/%0d want 0/0", bus.issue_valid, bus.issue_rob_tag); end
        n_checks++; if (bus.free_count !== 4'd8 || bus.rs_full !== 1'b0) begin n_fail++; $display("FAIL async_free got %0d/%0b want 8/0", bus.free_count, bus.rs_full); end
        reset = 1'b1;
        model_clear();
        dispatch(17, 0, 0);
        tick(); idle(); peek();
        n_checks++; if (bus.issue_valid !== 1'b1 || bus.issue_rob_tag !== 5'd17) begin n_fail++; $display("FAIL async_first got %0b/%0d want 1/17", bus.issue_valid, bus.issue_rob_tag); end
    endtask

    task automatic test_random();
        flush();
        for (int c = 0; c < 400; c++) begin
            idle();
            if ($urandom_range(0, 3) != 0) begin
                dispatch($urandom_range(1, 31), $urandom_range(0, 7), $urandom_range(0, 7));
                bus.dp_tplus_a = ($urandom_range(0, 5) == 0);
                bus.dp_tplus_b = ($urandom_range(0, 5) == 0);
            end
            bus.cdb_valid = $urandom_range(0, 1);
            bus.cdb_tag = TAG_W'($urandom_range(0, 7));
            bus.mispredict = ($urandom_range(0, 15) == 0);
            bus.br_rob_tag = TAG_W'($urandom_range(0, 31));
            bus.rob_tail = TAG_W'($urandom_range(0, 31));
            bus.issue_ready = ($urandom_range(0, 2) != 0);
            peek();
            n_checks++; if (bus.issue_valid !== e_valid) begin n_fail++; $display("FAIL rand_valid cyc %0d got %0b want %0b", c, bus.issue_valid, e_valid); end
            n_checks++; if (bus.issue_rob_tag !== e_rob || bus.issue_tag_a !== e_ta || bus.issue_tag_b !== e_tb) begin n_fail++; $display("FAIL rand_tags cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d", c, bus.issue_rob_tag, bus.issue_tag_a, bus.issue_tag_b, e_rob, e_ta, e_tb); end
            n_checks++; if (bus.issue_payload !== e_pay) begin n_fail++; $display("FAIL rand_payload cyc %0d got %h want %h", c, bus.issue_payload, e_pay); end
            n_checks++; if (bus.free_count !== e_free || bus.rs_full !== e_full) begin n_fail++; $display("FAIL rand_occupancy cyc %0d got %0d/%0b want %0d/%0b", c, bus.free_count, bus.rs_full, e_free, e_full); end
            tick();
        end
        idle();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_wakeup();
        test_fill();
        test_priority();
        test_squash();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rs_station.md
# rs_station

Reservation station that sits directly downstream of the map table in the dispatch stage. Each cycle it accepts at most one dispatched instruction together with the two source-operand tags the map table resolved. It tracks operand readiness against CDB broadcasts and issues one ready instruction per cycle to the execute stage over a valid/ready handshake. It also selectively squashes entries younger than a mispredicted branch.

## Interface
Parameters:
- RS_SZ, 8, number of entries (power of two, ≥2)
- TAG_W, 5, ROB tag width; tag 0 is reserved and means "no producer, value in register file"
- PAYLOAD_W, 64, opaque decoded-instruction payload carried to execute

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset; clears all state immediately when low
- dispatch_valid  in  1  dispatch request this cycle
- dp_rob_tag  in  TAG_W  destination ROB tag of the dispatched instruction (nonzero)
- dp_tag_a, dp_tag_b  in  TAG_W  source tags from the map table (0 = no dependency)
- dp_tplus_a, dp_tplus_b  in  1  map-table t_plus: the producer has completed and the value is in the ROB
- dp_payload  in  PAYLOAD_W  instruction payload
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  completing ROB tag
- mispredict  in  1  branch mispredict squash
- br_rob_tag  in  TAG_W  ROB tag of the mispredicted branch
- rob_tail  in  TAG_W  current ROB tail tag (youngest allocated)
- issue_valid  out  1  an entry is presented for issue
- issue_ready  in  1  execute stage accepts
- issue_rob_tag  out  TAG_W  destination tag of the presented entry
- issue_tag_a, issue_tag_b  out  TAG_W  source tags of the presented entry (for ROB/RF operand read)
- issue_payload  out  PAYLOAD_W  payload of the presented entry
- rs_full  out  1  all entries busy
- free_count  out  $clog2(RS_SZ)+1  number of non-busy entries

## Operation
- Each entry stores: busy, rob_tag, tag_a, rdy_a, tag_b, rdy_b, payload.
- Allocation: if dispatch_valid && !rs_full && !mispredict, write the lowest-index non-busy entry. rdy_x = (dp_tag_x==0) || dp_tplus_x || (cdb_valid && cdb_tag==dp_tag_x && dp_tag_x!=0).
- Dispatch while rs_full is dropped silently; the dispatcher must stall on rs_full.
- Wakeup: on cdb_valid with cdb_tag≠0, every busy entry with tag_x==cdb_tag sets rdy_x. cdb_tag==0 is ignored.
- Select: the candidate is the lowest-index busy entry with rdy_a&&rdy_b. issue_valid = candidate exists && !mispredict. The issue_* outputs show the candidate's fields and are zero when issue_valid=0.
- On issue_valid&&issue_ready, the candidate's busy bit clears at the clock edge.
- Squash: when mispredict=1, clear every busy entry whose rob_tag lies in the circular window (br_rob_tag, rob_tail].
  - If br_rob_tag≤rob_tail, the window is br<t≤tail.
  - Otherwise it is t>br || t≤tail.
  - The branch's own entry and older entries survive. Surviving entries still take CDB wakeups that cycle.
- rs_full = (free_count==0). Both are derived from registered busy bits only.

## Timing
- Reset (reset=0, asynchronous): all busy=0. Outputs: issue_valid=0, issue_* =0, rs_full=0, free_count=RS_SZ.
- Dispatch in cycle N: the entry is visible from N+1. The earliest issue_valid for it is N+1 if both operands were ready at capture, including same-cycle CDB bypass.
- Wakeup in cycle N: the entry is issuable in N+1. There is no same-cycle CDB→issue path.
- Issue and dispatch in the same cycle are both performed. A slot freed by issue in cycle N is allocatable only from N+1, so rs_full does not combinationally depend on issue_ready.
- Squash has priority over issue and dispatch in its cycle: issue_valid=0, no allocation, no handshake completes.
- issue_valid may drop without issue_ready, e.g. on mispredict. The consumer samples only on valid&&ready.
- Reset asserted mid-operation discards all entries immediately. The first dispatch is accepted at the first rising edge after deassertion.

## Test plan
- Reset then single independent dispatch: cycle 1 dispatch rob_tag=3, tag_a=tag_b=0 → cycle 2 issue_valid=1, issue_rob_tag=3. Hold issue_ready=1 → cycle 3 issue_valid=0, free_count=8.
- Dependency wakeup: dispatch rob_tag=5, tag_a=2, tplus_a=0 → issue_valid stays 0. cdb_valid with cdb_tag=2 in cycle 4 → issue_valid=1 in cycle 5, issue_tag_a=2. Also cover the same-cycle CDB at dispatch (cdb_tag==dp_tag_a) → issue next cycle.
- Fill and backpressure: 8 dependent dispatches → rs_full=1, free_count=0. A 9th dispatch is dropped and free_count stays 0. Release one with a CDB and issue it → rs_full=0 the cycle after the handshake.
- Priority and hold: entries 0 and 2 ready, issue_ready=0 for 3 cycles → issue_rob_tag stays entry 0's tag. Then accept → entry 2 is presented next.
- Wrap-around squash: busy tags 29,30,31,1,2 with br_rob_tag=30, rob_tail=2, mispredict=1 → tags 31,1,2 cleared, 29,30 kept, issue_valid=0 that cycle. Also cover the non-wrap case br=4, tail=7 → tags 5..7 cleared.
- Async reset mid-flight: 5 busy entries, reset pulsed low between edges → outputs zero immediately, free_count=8 without a clock edge.
